pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_seq_pkg.sv | 35 +++
 rtl/pll_rst_seq_sync_2ff.sv | 33 +++
 rtl/pll_rst_seq.sv | 151 +++++++++++++++
 tb/tb_pll_rst_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_pkg
// Shared types and helpers for the PLL reset sequencer.
//   state_t  : sequencer states, in the order they are normally visited
//   cnt_w    : width of the shared state timer, sized from the largest
//              timing parameter
//   sat_inc  : 8-bit saturating increment used by the event counters
// ---------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    // The timer only ever counts up to (parameter - 1), so clog2 of the
    // largest parameter plus one spare bit always covers it.
    function automatic int cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    // Event counters stick at 255 instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for signals that are asynchronous to clk.
// Both flops clear to 0 on reset.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// ---------------------------------------------------------------------------
// pll_rst_seq
// Drives the PLL reset, waits for a stable lock, then releases downstream
// reset domains one at a time. Lock loss pulls every domain back into reset
// and re-runs the sequence; a lock that never arrives retries the PLL.
// Ports:
//   sys_clk   : free-running board clock, the only clock
//   sys_rst   : asynchronous active-high reset
//   locked    : PLL lock indicator, asynchronous to sys_clk
//   rst_req   : synchronous request for a full re-sequence
//   pll_reset : active-high reset to the PLL
//   stage_rst : active-high domain resets, bit 0 released first
//   ready     : all stages released and lock held
//   retry_cnt : saturating count of lock timeouts
//   loss_cnt  : saturating count of lock losses while running
// ---------------------------------------------------------------------------
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STABLE_CYC   = 1024,
    parameter int N_STAGE      = 4,
    parameter int STAGE_GAP    = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               locked,
    input  logic               rst_req,
    output logic               pll_reset,
    output logic [N_STAGE-1:0] stage_rst,
    output logic               ready,
    output logic [7:0]         retry_cnt,
    output logic [7:0]         loss_cnt
);

    localparam int CW = cnt_w(PLL_RST_CYC, LOCK_TIMEOUT, STABLE_CYC, STAGE_GAP);

    // Terminal values of the shared timer for each timed state.
    localparam logic [CW-1:0] PLL_LAST     = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(sys_clk),
        .rst(sys_rst),
        .d  (locked),
        .q  (lock_s)
    );

    // Sequencer. cnt counts cycles spent in the current state (or since the
    // last stage release) and is cleared on every state entry. Stage resets
    // are released by shifting zeros in from bit 0, so the vector empties in
    // order and "all released" is simply stage_rst == 0. Any re-assertion
    // loads the whole vector with ones at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            stage_rst <= '1;
            ready     <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else if (rst_req) begin
            // Also covers PLL_RST itself: a held request keeps the timer at 0.
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            stage_rst <= '1;
            ready     <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        retry_cnt <= sat_inc(retry_cnt);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= RELEASE;
                        cnt       <= '0;
                        stage_rst <= stage_rst << 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        stage_rst <= '1;
                    end else if (stage_rst == '0) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        stage_rst <= stage_rst << 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        loss_cnt  <= sat_inc(loss_cnt);
                    end
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    stage_rst <= '1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_rst_seq
// Self-checking bench for pll_rst_seq with small timing parameters.
// A behavioural model tracks the sequencer as "phase + cycles in phase" and
// derives the expected outputs from elapsed time; it is compared every cycle.
// Hand-computed vectors and sequences cover the timing corner cases.
// ---------------------------------------------------------------------------
module tb_pll_rst_seq;

    localparam int PLL_RST_CYC  = 16;
    localparam int LOCK_TIMEOUT = 100;
    localparam int STABLE_CYC   = 32;
    localparam int N_STAGE      = 4;
    localparam int STAGE_GAP    = 8;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               locked;
    logic               rst_req;
    logic               pll_reset;
    logic [N_STAGE-1:0] stage_rst;
    logic               ready;
    logic [7:0]         retry_cnt;
    logic [7:0]         loss_cnt;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    pll_rst_seq #(
        .PLL_RST_CYC (PLL_RST_CYC),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYC  (STABLE_CYC),
        .N_STAGE     (N_STAGE),
        .STAGE_GAP   (STAGE_GAP)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .locked   (locked),
        .rst_req  (rst_req),
        .pll_reset(pll_reset),
        .stage_rst(stage_rst),
        .ready    (ready),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: the phase the sequencer is in, how many cycles it has
    // spent there, the two-cycle delayed view of locked, and event counts.
    typedef enum int {M_RST, M_WAIT, M_STABLE, M_REL, M_RUN} phase_t;
    phase_t m_phase;
    int     m_t;
    bit     m_s1, m_s2;
    int     m_retry, m_loss;

    function automatic void modelReset();
        m_phase = M_RST;
        m_t     = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_retry = 0;
        m_loss  = 0;
    endfunction

    function automatic void modelGo(input phase_t p);
        m_phase = p;
        m_t     = 0;
    endfunction

    function automatic void modelStep(input bit lk_in, input bit rq);
        bit lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk_in;
        if (rq) begin
            modelGo(M_RST);
        end else begin
            case (m_phase)
                M_RST:    if (m_t + 1 == PLL_RST_CYC) modelGo(M_WAIT); else m_t++;
                M_WAIT: begin
                    if (lk) modelGo(M_STABLE);
                    else if (m_t + 1 == LOCK_TIMEOUT) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        modelGo(M_RST);
                    end else m_t++;
                end
                M_STABLE: if (!lk) modelGo(M_WAIT);
                          else if (m_t + 1 == STABLE_CYC) modelGo(M_REL);
                          else m_t++;
                M_REL:    if (!lk) modelGo(M_WAIT);
                          else if (m_t == (N_STAGE - 1) * STAGE_GAP) modelGo(M_RUN);
                          else m_t++;
                M_RUN: begin
                    if (!lk) begin
                        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                        modelGo(M_WAIT);
                    end
                end
                default:  modelGo(M_RST);
            endcase
        end
    endfunction

    // Compare every output against a full set of expected values.
    task automatic checkOutput(input string name, input logic e_pll, input logic [N_STAGE-1:0] e_stage,
                               input logic e_ready, input logic [7:0] e_retry, input logic [7:0] e_loss);
        checks++;
        if (pll_reset !== e_pll || stage_rst !== e_stage || ready !== e_ready ||
            retry_cnt !== e_retry || loss_cnt !== e_loss) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got pll_reset=%b stage_rst=%b ready=%b retry=%0d loss=%0d, expected pll_reset=%b stage_rst=%b ready=%b retry=%0d loss=%0d",
                     name, $time, pll_reset, stage_rst, ready, retry_cnt, loss_cnt,
                     e_pll, e_stage, e_ready, e_retry, e_loss);
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp_val);
        checks++;
        if (act != exp_val) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp_val);
        end
    endtask

    task automatic applyStimulus(input bit lk, input bit rq);
        locked  = lk;
        rst_req = rq;
    endtask

    // One clock: step the model with the inputs seen at the edge, then
    // compare the DUT against the model 1 ns later.
    task automatic tick();
        logic [N_STAGE-1:0] es;
        @(posedge sys_clk);
        if (sys_rst) modelReset();
        else begin
            modelStep(locked, rst_req);
            edge_no++;
        end
        #1;
        for (int k = 0; k < N_STAGE; k++)
            es[k] = (m_phase == M_RUN) ? 1'b0 : (m_phase == M_REL) ? (m_t < k * STAGE_GAP) : 1'b1;
        checkOutput("model", m_phase == M_RST, es, m_phase == M_RUN, 8'(m_retry), 8'(m_loss));
    endtask

    task automatic tickUntil(input int n);
        while (edge_no < n) tick();
    endtask

    task automatic waitReady(input string name, input int max_cyc);
        int n = 0;
        while (!ready && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("[TB] FAIL %s: ready=%b after %0d cycles, expected 1", name, ready, max_cyc);
        end
    endtask

    task automatic doReset(input bit lk);
        applyStimulus(lk, 1'b0);
        sys_rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_state", 1'b1, '1, 1'b0, 8'd0, 8'd0);
        sys_rst = 1'b0;
        edge_no = 0;
    endtask

    typedef struct {
        int                 at_edge;
        bit                 lk;
        bit                 rq;
        logic               e_pll;
        logic [N_STAGE-1:0] e_stage;
        logic               e_ready;
    } vec_t;

    vec_t vecs[10];
    int   hold;
    bit   rnd_lk;

    initial begin
        // Release timeline with locked tied high, counted in edges after reset.
        vecs[0] = '{15, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[1] = '{16, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[2] = '{48, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[3] = '{49, 1'b1, 1'b0, 1'b0, 4'hE, 1'b0};
        vecs[4] = '{56, 1'b1, 1'b0, 1'b0, 4'hE, 1'b0};
        vecs[5] = '{57, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0};
        vecs[6] = '{64, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0};
        vecs[7] = '{65, 1'b1, 1'b0, 1'b0, 4'h8, 1'b0};
        vecs[8] = '{73, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[9] = '{74, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};

        $display("[TB] release timeline");
        doReset(1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].lk, vecs[i].rq);
            tickUntil(vecs[i].at_edge);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_pll, vecs[i].e_stage, vecs[i].e_ready, 8'd0, 8'd0);
        end

        $display("[TB] lock glitch in STABLE");
        doReset(1'b1);
        tickUntil(37);
        applyStimulus(1'b0, 1'b0);
        tickUntil(40);
        applyStimulus(1'b1, 1'b0);
        tickUntil(49);
        checkField("glitch_stage_hold", int'(stage_rst), 15);
        waitReady("glitch_ready", 200);
        checkField("glitch_ready_edge", edge_no, 100);
        checkField("glitch_loss", int'(loss_cnt), 0);

        $display("[TB] lock loss in RUN");
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkField("loss_stage", int'(stage_rst), 15);
        checkField("loss_ready", int'(ready), 0);
        checkField("loss_cnt", int'(loss_cnt), 1);
        checkField("loss_pll", int'(pll_reset), 0);
        applyStimulus(1'b1, 1'b0);
        waitReady("relock_ready", 300);
        checkField("relock_edge", edge_no, 163);

        $display("[TB] short async reset in RUN");
        sys_rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", 1'b1, '1, 1'b0, 8'd0, 8'd0);
        #2;
        sys_rst = 1'b0;
        edge_no = 0;
        tickUntil(5);

        $display("[TB] rst_req during RELEASE");
        doReset(1'b1);
        tickUntil(58);
        checkField("pre_req_stage", int'(stage_rst), 12);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkField("req_stage", int'(stage_rst), 15);
        checkField("req_pll", int'(pll_reset), 1);
        tickUntil(74);
        checkField("req_pll_hold", int'(pll_reset), 1);
        tick();
        checkField("req_pll_fall", int'(pll_reset), 0);
        waitReady("req_ready", 300);
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkField("req_vs_loss_pll", int'(pll_reset), 1);
        checkField("req_vs_loss_cnt", int'(loss_cnt), 0);

        $display("[TB] never lock");
        doReset(1'b0);
        tickUntil(16);
        checkField("nl_pll_fall", int'(pll_reset), 0);
        tickUntil(115);
        checkField("nl_pll_before_retry", int'(pll_reset), 0);
        tick();
        checkField("nl_pll_retry", int'(pll_reset), 1);
        checkField("nl_retry1", int'(retry_cnt), 1);
        tickUntil(131);
        checkField("nl_pll_hold", int'(pll_reset), 1);
        tick();
        checkField("nl_pll_fall2", int'(pll_reset), 0);
        tickUntil(348);
        checkField("nl_retry3", int'(retry_cnt), 3);
        tickUntil(29700);
        checkField("nl_retry_sat", int'(retry_cnt), 255);

        $display("[TB] loss counter saturation");
        doReset(1'b1);
        for (int i = 0; i < 260; i++) begin
            waitReady("sat_ready", 400);
            applyStimulus(1'b0, 1'b0);
            repeat (4) tick();
            applyStimulus(1'b1, 1'b0);
        end
        waitReady("sat_final_ready", 400);
        checkField("loss_sat", int'(loss_cnt), 255);

        $display("[TB] randomized run");
        doReset(1'b1);
        hold = 0;
        rnd_lk = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (hold == 0) begin
                rnd_lk = ($urandom_range(0, 3) != 0);
                hold   = $urandom_range(1, 120);
            end
            hold--;
            applyStimulus(rnd_lk, $urandom_range(0, 99) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
